// File: rtl/emu_scan_pkg.sv
// Shared types for the emulator RAM scan-chain checkpoint controller:
// FSM states, transfer directions, word width and the running checksum step.
package emu_scan_pkg;

  localparam int unsigned SCAN_WORD_W = 64;

  localparam logic DIR_DUMP    = 1'b0;
  localparam logic DIR_RESTORE = 1'b1;

  typedef logic [SCAN_WORD_W-1:0] scan_word_t;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    DUMP,
    RESTORE,
    TAIL,
    UNHALT
  } scan_state_e;

  function automatic scan_word_t csum_update(input scan_word_t csum, input scan_word_t word);
    return {csum[SCAN_WORD_W-2:0], csum[SCAN_WORD_W-1]} ^ word;
  endfunction

endpackage

// File: rtl/emu_ram_scan_ctrl_if.sv
// Host command, word streams and emulator RAM scan-chain signals of the checkpoint controller.
// master: the controller; slave: host/DMA plus EMU_DUT scan ports.
interface emu_ram_scan_ctrl_if;
  import emu_scan_pkg::*;

  logic       cmd_valid;
  logic       cmd_dir;
  logic       cmd_ready;
  logic       done;
  logic       busy;
  logic       out_valid;
  scan_word_t out_data;
  logic       out_ready;
  logic       in_valid;
  scan_word_t in_data;
  logic       in_ready;
  logic       halt;
  logic       ram_scan;
  logic       ram_dir;
  scan_word_t ram_sdi;
  scan_word_t ram_sdo;

  modport master (
    input  cmd_valid, cmd_dir, out_ready, in_valid, in_data, ram_sdo,
    output cmd_ready, done, busy, out_valid, out_data, in_ready,
           halt, ram_scan, ram_dir, ram_sdi
  );

  modport slave (
    output cmd_valid, cmd_dir, out_ready, in_valid, in_data, ram_sdo,
    input  cmd_ready, done, busy, out_valid, out_data, in_ready,
           halt, ram_scan, ram_dir, ram_sdi
  );

endinterface

// File: rtl/emu_scan_fifo.sv
// Synchronous word FIFO buffering dumped scan words toward the out stream.
// Caller guarantees no push when full; pop on empty is ignored.
module emu_scan_fifo
  import emu_scan_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  scan_word_t                   push_data,
  input  logic                         pop,
  output scan_word_t                   pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  scan_word_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/emu_ram_scan_ctrl.sv
// Checkpoint dump/restore sequencer for the EMU_DUT RAM scan chain.
// Optional EMU_SCAN_CSUM_EN adds a rotate-xor checksum over transferred words.
module emu_ram_scan_ctrl
  import emu_scan_pkg::*;
#(
  parameter int unsigned CHAIN_WORDS = 16,
  parameter int unsigned SDO_LAT     = 2,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  emu_ram_scan_ctrl_if.master bus
`ifdef EMU_SCAN_CSUM_EN
  ,
  output scan_word_t          csum,
  output logic                csum_valid
`endif
);

  localparam int unsigned IW  = $clog2(CHAIN_WORDS + 1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  scan_state_e        state, state_n;
  logic               dir_q;
  logic [IW-1:0]      issued;
  logic [SDO_LAT-1:0] vpipe;
  logic               done_q;
  logic               accept;
  logic               scan;
  logic               issue_inc;
  logic               issued_full;
  logic               finishing;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic [FCW-1:0]     fifo_count;
  scan_word_t         fifo_data;
  logic [31:0]        free_slots;
  logic [31:0]        inflight;

  assign accept      = bus.cmd_valid && (state == IDLE);
  assign issued_full = (issued == IW'(CHAIN_WORDS));
  assign issue_inc   = scan && ((state == DUMP) || (state == RESTORE));
  assign finishing   = (state == UNHALT) && (state_n == IDLE);
  // Reserve FIFO room for every word still travelling through the SDO latency.
  assign free_slots  = 32'(FIFO_DEPTH) - 32'(fifo_count);
  assign inflight    = 32'($countones(vpipe));
  assign fifo_push   = vpipe[SDO_LAT-1];
  assign fifo_pop    = bus.out_ready && !fifo_empty;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.ram_scan  = scan;
  assign bus.ram_dir   = dir_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_data;

  always_comb begin
    state_n      = state;
    scan         = 1'b0;
    bus.in_ready = 1'b0;
    bus.ram_sdi  = '0;
    bus.halt     = 1'b1;
    case (state)
      IDLE: begin
        bus.halt = 1'b0;
        if (accept) state_n = HALT;
      end
      HALT: state_n = (dir_q == DIR_RESTORE) ? RESTORE : DUMP;
      DUMP: begin
        scan = !issued_full && (free_slots > inflight);
        if (issued_full && (vpipe == '0)) state_n = TAIL;
      end
      RESTORE: begin
        bus.in_ready = !issued_full;
        scan         = bus.in_valid && !issued_full;
        if (scan) bus.ram_sdi = bus.in_data;
        // Leave on the last word's cycle so TAIL follows without an idle gap.
        if (issued_full || (scan && (issued == IW'(CHAIN_WORDS - 1)))) state_n = TAIL;
      end
      TAIL: begin
        scan    = (dir_q == DIR_RESTORE);
        state_n = UNHALT;
      end
      UNHALT: begin
        if ((dir_q == DIR_RESTORE) || fifo_empty) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dir_q  <= DIR_DUMP;
      issued <= '0;
      vpipe  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      vpipe  <= (vpipe << 1) | SDO_LAT'(issue_inc && (state == DUMP));
      done_q <= finishing;
      if (accept) begin
        dir_q  <= bus.cmd_dir;
        issued <= '0;
      end else if (issue_inc) begin
        issued <= issued + IW'(1);
      end
    end
  end

  emu_scan_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(bus.ram_sdo),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

`ifdef EMU_SCAN_CSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      csum       <= '0;
      csum_valid <= 1'b0;
    end else begin
      csum_valid <= finishing;
      if (accept)                         csum <= '0;
      else if (fifo_push)                 csum <= csum_update(csum, bus.ram_sdo);
      else if (scan && state == RESTORE)  csum <= csum_update(csum, bus.in_data);
    end
  end
`endif

endmodule
